mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Byte-serial memory controller sitting between the external 8-bit RAM/IO port and the two memory clients: the instruction fetcher (word reads) and the store/load buffer (byte/half/word reads and writes). Each client posts a one-cycle request pulse. The block latches it, arbitrates, and then streams the access one byte per cycle. It returns the assembled result with a one-cycle ready pulse. Misbranch flushes drop fetch traffic only; load/store traffic always completes.

## Interface
Parameters:
- IO_ADDR_LO, 32'h30000, first IO-mapped address subject to write back-pressure
- IO_ADDR_HI, 32'h30004, second IO-mapped address subject to write back-pressure

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- rdy  input  1  global enable; 0 freezes all registers
- has_misbranch  input  1  flush fetch side
- in_if_addr  input  32  fetch address
- in_if_ask  input  1  fetch request pulse
- out_if_inst  output  32  assembled instruction, little-endian
- out_if_ready  output  1  one-cycle pulse; out_if_inst valid this cycle
- in_ls_addr  input  32  load/store address
- in_ls_ask  input  1  load/store request pulse
- in_ls_wr  input  1  1 = store, 0 = load
- in_ls_size  input  2  0 byte, 1 half, 2 word (3 treated as word)
- in_ls_data  input  32  store data, low bytes used
- out_ls_data  output  32  load data, zero-extended
- out_ls_ready  output  1  one-cycle pulse on load data valid / store done
- mem_din  input  8  RAM read byte; 1-cycle latency after mem_a
- mem_dout  output  8  RAM write byte
- mem_a  output  32  RAM byte address
- mem_wr  output  1  1 = write this cycle
- io_buffer_full  input  1  IO write back-pressure

## Operation
- Pending registers: if_pend and ls_pend, each with latched address and attributes. They are set on the edge that samples the ask.
  - A new ask while pending overwrites the latched fields (last wins).
- States:
  - IDLE:
    - With ls_pend (or in_ls_ask this edge), go to LS.
    - Otherwise, with if_pend (or in_if_ask), go to IF.
    - LS has priority over IF.
    - The start edge also clears the corresponding pending bit.
  - IF: 4-byte read.
  - LS_RD: N-byte read, N = 1/2/4 from size.
  - LS_WR: N-byte write.
  - IO_WAIT: store to IO_ADDR_LO/IO_ADDR_HI while io_buffer_full = 1.
    - Hold with mem_wr = 0 until io_buffer_full = 0, then go to LS_WR.
- Byte order and addressing:
  - Byte k goes to address base+k (32-bit wrap-around mod 2^32). Unaligned accesses are legal.
  - Byte k lands in bits [8k+7:8k].
- Reads: the byte k address is driven in byte-cycle k. mem_din carries byte k in byte-cycle k+1 and is captured at the end of it.
- Writes: mem_wr = 1, mem_a = base+k, mem_dout = in_ls_data byte k, in byte-cycle k.
- Completion:
  - The state returns to IDLE on the edge that raises the ready pulse.
  - The next access starts no earlier than the following edge, so there is one idle cycle between accesses.
- has_misbranch sampled high:
  - Clears if_pend.
  - Drops an in_if_ask sampled on the same edge.
  - Aborts IF to IDLE with no out_if_ready.
  - LS_RD, LS_WR, IO_WAIT and ls_pend are unaffected.
- Idle drive: mem_wr = 0, mem_a = 0, mem_dout = 0.
- rdy = 0: every register holds and mem_wr is gated to 0. Clients do not issue asks while rdy = 0.

## Timing
- Reset (rst = 0, immediate): state IDLE, pending bits cleared.
  - All outputs 0: out_if_inst, out_if_ready, out_ls_data, out_ls_ready, mem_dout, mem_a, mem_wr.
- Cycle numbering: the ask is sampled at edge E0 with the block idle; cycle n follows edge En.
  - mem_a = base during cycle 0.
- Fetch:
  - mem_a = base+k in cycle k (k = 0..3).
  - Byte k captured at E(k+2).
  - out_if_ready = 1 in cycle 5 only, with out_if_inst = {byte3, byte2, byte1, byte0}.
- Load of N bytes: out_ls_ready in cycle N+1. Bytes beyond N read as 0.
- Store of N bytes: writes in cycles 0..N-1; out_ls_ready in cycle N.
- IO_WAIT: each wait cycle adds one cycle to the store latency.
- Simultaneous asks when idle: LS starts at E0. IF starts at the edge after LS's ready pulse.
- Ready pulses never overlap; exactly one pulse per completed request.

## Test plan
- Fetch at 0x0 with RAM bytes 13 00 00 00: ask at E0 -> mem_a = 0,1,2,3 in cycles 0–3; out_if_ready only in cycle 5 with out_if_inst = 32'h00000013.
- Store word 0xDEADBEEF to 0x100 -> mem_wr with bytes EF, BE, AD, DE at 0x100–0x103 in cycles 0–3; out_ls_ready in cycle 4. Follow with a load half at 0x101 -> out_ls_data = 32'h0000ADBE in cycle 3.
- LS and IF asks on the same edge -> the LS byte load completes first (ready cycle 2); the fetch starts at E3 and its ready pulse arrives 5 cycles later.
- has_misbranch in cycle 2 of a fetch -> no out_if_ready, mem_a = 0 from the next cycle. A concurrent pending load still returns correct data.
- Byte store to 0x30000 with io_buffer_full = 1 for 3 cycles -> mem_wr stays 0 for those cycles; the write and out_ls_ready then occur with latency 3 + 1.
- Assert rst low mid-fetch -> all outputs 0 at once; the fetch is never reported after rst releases.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Client and RAM/IO bus of the byte-serial memory arbiter.
// The arbiter takes the slave side; clients and the RAM model take the master side.
interface mem_arbiter_if;
    logic        has_misbranch;

    logic [31:0] in_if_addr;
    logic        in_if_ask;
    logic [31:0] out_if_inst;
    logic        out_if_ready;

    logic [31:0] in_ls_addr;
    logic        in_ls_ask;
    logic        in_ls_wr;
    logic [1:0]  in_ls_size;
    logic [31:0] in_ls_data;
    logic [31:0] out_ls_data;
    logic        out_ls_ready;

    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport slave (
        input  has_misbranch,
        input  in_if_addr, in_if_ask,
        input  in_ls_addr, in_ls_ask, in_ls_wr, in_ls_size, in_ls_data,
        input  mem_din, io_buffer_full,
        output out_if_inst, out_if_ready,
        output out_ls_data, out_ls_ready,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output has_misbranch,
        output in_if_addr, in_if_ask,
        output in_ls_addr, in_ls_ask, in_ls_wr, in_ls_size, in_ls_data,
        output mem_din, io_buffer_full,
        input  out_if_inst, out_if_ready,
        input  out_ls_data, out_ls_ready,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial controller between the 8-bit RAM/IO port and the
// instruction fetcher / load-store buffer. Requests are latched as pending,
// load/store wins over fetch, and each access streams one byte per cycle.
module mem_arbiter #(
    parameter logic [31:0] IO_ADDR_LO = 32'h30000,
    parameter logic [31:0] IO_ADDR_HI = 32'h30004
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    mem_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IF,
        S_LS_RD,
        S_LS_WR,
        S_IO_WAIT
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // byte-cycle index of the running access and its length
    logic [2:0]  cnt;
    logic [2:0]  nbytes;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] rbuf;
    logic [31:0] rbuf_ins;

    logic        if_pend;
    logic [31:0] if_addr_q;
    logic        ls_pend;
    logic [31:0] ls_addr_q;
    logic [31:0] ls_data_q;
    logic        ls_wr_q;
    logic [1:0]  ls_size_q;

    logic        ls_req;
    logic        if_req;
    logic [31:0] ls_addr_sel;
    logic [31:0] ls_data_sel;
    logic        ls_wr_sel;
    logic [1:0]  ls_size_sel;
    logic [31:0] if_addr_sel;
    logic        ls_is_io;
    logic        start_ls;
    logic        start_if;
    logic        rd_done;
    logic        wr_done;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Request selection: an ask on this edge overrides the latched fields
    always_comb begin
        ls_addr_sel = bus.in_ls_ask ? bus.in_ls_addr : ls_addr_q;
        ls_data_sel = bus.in_ls_ask ? bus.in_ls_data : ls_data_q;
        ls_wr_sel   = bus.in_ls_ask ? bus.in_ls_wr   : ls_wr_q;
        ls_size_sel = bus.in_ls_ask ? bus.in_ls_size : ls_size_q;
        if_addr_sel = bus.in_if_ask ? bus.in_if_addr : if_addr_q;
        ls_req      = ls_pend | bus.in_ls_ask;
        if_req      = (if_pend | bus.in_if_ask) & ~bus.has_misbranch;
        ls_is_io    = (ls_addr_sel == IO_ADDR_LO) || (ls_addr_sel == IO_ADDR_HI);
        start_ls    = (state == S_IDLE) && ls_req;
        start_if    = (state == S_IDLE) && !ls_req && if_req;
        rd_done     = (cnt == nbytes);
        wr_done     = (cnt == nbytes - 3'd1);
    end

    // Merge the byte arriving on mem_din into its lane (byte cnt-1 of the access)
    always_comb begin
        rbuf_ins = rbuf;
        case (cnt)
            3'd1:    rbuf_ins[7:0]   = bus.mem_din;
            3'd2:    rbuf_ins[15:8]  = bus.mem_din;
            3'd3:    rbuf_ins[23:16] = bus.mem_din;
            3'd4:    rbuf_ins[31:24] = bus.mem_din;
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the edge that raises a ready pulse returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ls_req) begin
                    if (!ls_wr_sel)
                        state_nxt = S_LS_RD;
                    else if (ls_is_io && bus.io_buffer_full)
                        state_nxt = S_IO_WAIT;
                    else
                        state_nxt = S_LS_WR;
                end else if (if_req) begin
                    state_nxt = S_IF;
                end
            end
            S_IF:      if (bus.has_misbranch || rd_done) state_nxt = S_IDLE;
            S_LS_RD:   if (rd_done) state_nxt = S_IDLE;
            S_LS_WR:   if (wr_done) state_nxt = S_IDLE;
            S_IO_WAIT: if (!bus.io_buffer_full) state_nxt = S_LS_WR;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Byte counter, pending flags and the registered ready/result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt              <= 3'd0;
            if_pend          <= 1'b0;
            ls_pend          <= 1'b0;
            bus.out_if_ready <= 1'b0;
            bus.out_ls_ready <= 1'b0;
            bus.out_if_inst  <= 32'd0;
            bus.out_ls_data  <= 32'd0;
        end else if (rdy) begin
            bus.out_if_ready <= 1'b0;
            bus.out_ls_ready <= 1'b0;

            if (state == S_IF || state == S_LS_RD || state == S_LS_WR)
                cnt <= cnt + 3'd1;
            else
                cnt <= 3'd0;

            if (bus.has_misbranch)
                if_pend <= 1'b0;
            else if (bus.in_if_ask)
                if_pend <= 1'b1;
            if (bus.in_ls_ask)
                ls_pend <= 1'b1;
            if (start_ls)
                ls_pend <= 1'b0;
            if (start_if)
                if_pend <= 1'b0;

            if (state == S_IF && rd_done && !bus.has_misbranch) begin
                bus.out_if_ready <= 1'b1;
                bus.out_if_inst  <= rbuf_ins;
            end
            if (state == S_LS_RD && rd_done) begin
                bus.out_ls_ready <= 1'b1;
                bus.out_ls_data  <= rbuf_ins;
            end
            if (state == S_LS_WR && wr_done)
                bus.out_ls_ready <= 1'b1;
        end
    end

    // Latched request fields and the active access' address, data and read buffer
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (bus.in_if_ask)
                if_addr_q <= bus.in_if_addr;
            if (bus.in_ls_ask) begin
                ls_addr_q <= bus.in_ls_addr;
                ls_data_q <= bus.in_ls_data;
                ls_wr_q   <= bus.in_ls_wr;
                ls_size_q <= bus.in_ls_size;
            end
            if (start_ls) begin
                base   <= ls_addr_sel;
                wdata  <= ls_data_sel;
                nbytes <= size_bytes(ls_size_sel);
                rbuf   <= 32'd0;
            end else if (start_if) begin
                base   <= if_addr_sel;
                nbytes <= 3'd4;
                rbuf   <= 32'd0;
            end else if ((state == S_IF || state == S_LS_RD) && cnt != 3'd0) begin
                rbuf   <= rbuf_ins;
            end
        end
    end

    // RAM port drive: address in byte-cycles 0..N-1, write strobe gated by rdy
    always_comb begin
        bus.mem_a    = 32'd0;
        bus.mem_wr   = 1'b0;
        bus.mem_dout = 8'd0;
        case (state)
            S_IF, S_LS_RD: begin
                if (cnt < nbytes)
                    bus.mem_a = base + {29'd0, cnt};
            end
            S_LS_WR: begin
                bus.mem_a  = base + {29'd0, cnt};
                bus.mem_wr = rdy;
                case (cnt[1:0])
                    2'd0:    bus.mem_dout = wdata[7:0];
                    2'd1:    bus.mem_dout = wdata[15:8];
                    2'd2:    bus.mem_dout = wdata[23:16];
                    default: bus.mem_dout = wdata[31:24];
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model on the byte port, directed scenarios and
// random traffic checked cycle by cycle against a timestamp-based job model.
module tb_mem_arbiter;

    localparam logic [31:0] IO_LO = 32'h30000;
    localparam logic [31:0] IO_HI = 32'h30004;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;

    mem_arbiter_if bus();

    mem_arbiter #(.IO_ADDR_LO(IO_LO), .IO_ADDR_HI(IO_HI)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // RAM seen by the DUT, and the model's own view of memory contents
    logic [7:0] ram     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
        bus.mem_din <= ram_rd(bus.mem_a);
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model: one job with a start timestamp ----------------
    int          t = 0;
    bit          m_on = 0, m_wait = 0;
    int          m_kind = 0;          // 0 fetch, 1 load, 2 store
    logic [31:0] m_addr = 0, m_data = 0;
    int          m_n = 0, m_t0 = 0;
    bit          p_if = 0, p_ls = 0, p_ls_wr = 0;
    logic [31:0] p_if_addr = 0, p_ls_addr = 0, p_ls_data = 0;
    int          p_ls_n = 0;
    bit          e_if_rdy = 0, e_ls_rdy = 0;
    logic [31:0] e_if_inst = 0, e_ls_data = 0;

    function automatic int bytes_of(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] w = 0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = ref_rd(a + 32'(k));
        return w;
    endfunction

    task automatic model_edge();
        bit idle;
        int done_at;
        t++;
        e_if_rdy = 0;
        e_ls_rdy = 0;
        idle = !m_on;
        if (m_on) begin
            done_at = m_t0 + ((m_kind == 2) ? m_n : m_n + 1);
            if (m_wait) begin
                if (!bus.io_buffer_full) begin m_wait = 0; m_t0 = t; end
            end else if (m_kind == 0 && bus.has_misbranch) begin
                m_on = 0;
            end else if (t == done_at) begin
                m_on = 0;
                if (m_kind == 0) begin e_if_rdy = 1; e_if_inst = ref_word(m_addr, 4); end
                else if (m_kind == 1) begin e_ls_rdy = 1; e_ls_data = ref_word(m_addr, m_n); end
                else begin
                    e_ls_rdy = 1;
                    for (int k = 0; k < m_n; k++) ref_mem[m_addr + 32'(k)] = m_data[8*k +: 8];
                end
            end
        end
        if (bus.in_ls_ask) begin
            p_ls = 1; p_ls_addr = bus.in_ls_addr; p_ls_data = bus.in_ls_data;
            p_ls_wr = bus.in_ls_wr; p_ls_n = bytes_of(bus.in_ls_size);
        end
        if (bus.has_misbranch) p_if = 0;
        else if (bus.in_if_ask) begin p_if = 1; p_if_addr = bus.in_if_addr; end
        if (idle) begin
            if (p_ls) begin
                m_on = 1; m_kind = p_ls_wr ? 2 : 1; m_addr = p_ls_addr; m_data = p_ls_data;
                m_n = p_ls_n; m_t0 = t; p_ls = 0;
                m_wait = p_ls_wr && (p_ls_addr == IO_LO || p_ls_addr == IO_HI) && bus.io_buffer_full;
            end else if (p_if) begin
                m_on = 1; m_kind = 0; m_addr = p_if_addr; m_n = 4; m_t0 = t; m_wait = 0; p_if = 0;
            end
        end
    endtask

    task automatic check_cycle();
        logic [31:0] ea = 0;
        logic        ew = 0;
        logic [7:0]  ed = 0;
        int p;
        if (m_on && !m_wait) begin
            p = t - m_t0;
            if (p < m_n) begin
                ea = m_addr + 32'(p);
                if (m_kind == 2) begin ew = 1; ed = m_data[8*p +: 8]; end
            end
        end
        chk_eq("mem_a", bus.mem_a, ea);
        chk_eq("mem_wr", {31'd0, bus.mem_wr}, {31'd0, ew});
        chk_eq("mem_dout", {24'd0, bus.mem_dout}, {24'd0, ed});
        chk_eq("if_ready", {31'd0, bus.out_if_ready}, {31'd0, e_if_rdy});
        chk_eq("ls_ready", {31'd0, bus.out_ls_ready}, {31'd0, e_ls_rdy});
        if (e_if_rdy) chk_eq("if_inst", bus.out_if_inst, e_if_inst);
        if (e_ls_rdy) chk_eq("ls_data", bus.out_ls_data, e_ls_data);
    endtask

    // one model-checked clock: inputs already driven at the negedge
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_cycle();
        bus.in_if_ask = 0;
        bus.in_ls_ask = 0;
        bus.has_misbranch = 0;
    endtask

    task automatic raw_step();
        @(posedge clk);
        @(negedge clk);
        bus.in_if_ask = 0;
        bus.in_ls_ask = 0;
    endtask

    task automatic ls_ask(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        bus.in_ls_ask = 1; bus.in_ls_wr = wr; bus.in_ls_size = sz;
        bus.in_ls_addr = a; bus.in_ls_data = d;
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        ref_mem[a] = b;
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 5))
            0:       return IO_LO;
            1:       return IO_HI;
            2:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            default: return 32'h100 + 32'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        chk_eq({tag, "_inst"}, bus.out_if_inst, 32'd0);
        chk_eq({tag, "_ifrdy"}, {31'd0, bus.out_if_ready}, 32'd0);
        chk_eq({tag, "_lsdata"}, bus.out_ls_data, 32'd0);
        chk_eq({tag, "_lsrdy"}, {31'd0, bus.out_ls_ready}, 32'd0);
        chk_eq({tag, "_dout"}, {24'd0, bus.mem_dout}, 32'd0);
        chk_eq({tag, "_a"}, bus.mem_a, 32'd0);
        chk_eq({tag, "_wr"}, {31'd0, bus.mem_wr}, 32'd0);
    endtask

    initial begin
        bus.has_misbranch = 0; bus.in_if_ask = 0; bus.in_if_addr = 0;
        bus.in_ls_ask = 0; bus.in_ls_wr = 0; bus.in_ls_size = 0;
        bus.in_ls_addr = 0; bus.in_ls_data = 0; bus.io_buffer_full = 0;
        poke(32'h0, 8'h13); poke(32'h1, 8'h00); poke(32'h2, 8'h00); poke(32'h3, 8'h00);

        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;

        // fetch at 0 -> 0x00000013 in cycle 5
        bus.in_if_ask = 1; bus.in_if_addr = 32'h0;
        step();
        repeat (5) step();
        chk_eq("tp_fetch_rdy", {31'd0, bus.out_if_ready}, 32'd1);
        chk_eq("tp_fetch_inst", bus.out_if_inst, 32'h0000_0013);
        step();

        // store word then half load from the middle of it
        ls_ask(1, 2'd2, 32'h100, 32'hDEAD_BEEF);
        step();
        repeat (4) step();
        chk_eq("tp_store_rdy", {31'd0, bus.out_ls_ready}, 32'd1);
        ls_ask(0, 2'd1, 32'h101, 32'h0);
        step();
        repeat (3) step();
        chk_eq("tp_half_rdy", {31'd0, bus.out_ls_ready}, 32'd1);
        chk_eq("tp_half_data", bus.out_ls_data, 32'h0000_ADBE);
        repeat (2) step();

        // simultaneous asks: byte load first, fetch starts E3, ready cycle 8
        ls_ask(0, 2'd0, 32'h103, 32'h0);
        bus.in_if_ask = 1; bus.in_if_addr = 32'h0;
        step();
        repeat (2) step();
        chk_eq("tp_both_ls", bus.out_ls_data, 32'h0000_00DE);
        repeat (6) step();
        chk_eq("tp_both_if", {31'd0, bus.out_if_ready}, 32'd1);
        repeat (2) step();

        // misbranch during cycle 2 of a fetch with a pending word load
        bus.in_if_ask = 1; bus.in_if_addr = 32'h104;
        step();
        ls_ask(0, 2'd2, 32'h100, 32'h0);
        step();
        step();
        bus.has_misbranch = 1;
        step();
        chk_eq("tp_flush_a", bus.mem_a, 32'h0);
        repeat (6) step();
        chk_eq("tp_flush_ls", bus.out_ls_data, 32'hDEAD_BEEF);
        repeat (2) step();

        // IO store held off by io_buffer_full for three sampled edges
        bus.io_buffer_full = 1;
        ls_ask(1, 2'd0, IO_LO, 32'h0000_005A);
        step();
        step();
        step();
        bus.io_buffer_full = 0;
        step();
        chk_eq("tp_io_wr", {31'd0, bus.mem_wr}, 32'd1);
        chk_eq("tp_io_dout", {24'd0, bus.mem_dout}, 32'h5A);
        step();
        chk_eq("tp_io_rdy", {31'd0, bus.out_ls_ready}, 32'd1);
        repeat (2) step();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.in_if_ask = 1; bus.in_if_addr = rnd_addr();
            end
            if ($urandom_range(0, 3) == 0)
                ls_ask(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rnd_addr(), $urandom);
            bus.has_misbranch = ($urandom_range(0, 9) == 0);
            bus.io_buffer_full = ($urandom_range(0, 2) == 0);
            step();
        end
        bus.io_buffer_full = 0;
        repeat (20) step();

        // rdy = 0 freezes a store in flight and gates mem_wr
        ls_ask(1, 2'd2, 32'h200, 32'h1122_3344);
        raw_step();
        chk_eq("rdy_c0_a", bus.mem_a, 32'h200);
        raw_step();
        chk_eq("rdy_c1_dout", {24'd0, bus.mem_dout}, 32'h33);
        rdy = 0;
        raw_step();
        chk_eq("rdy_hold_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk_eq("rdy_hold_a", bus.mem_a, 32'h201);
        raw_step();
        chk_eq("rdy_hold_wr2", {31'd0, bus.mem_wr}, 32'd0);
        rdy = 1;
        raw_step();
        chk_eq("rdy_c2_a", bus.mem_a, 32'h202);
        chk_eq("rdy_c2_wr", {31'd0, bus.mem_wr}, 32'd1);
        raw_step();
        raw_step();
        chk_eq("rdy_done", {31'd0, bus.out_ls_ready}, 32'd1);
        chk_eq("rdy_ram", {24'd0, ram_rd(32'h203)}, 32'h11);
        repeat (2) raw_step();

        // asynchronous reset in the middle of a fetch
        bus.in_if_ask = 1; bus.in_if_addr = 32'h10;
        raw_step();
        raw_step();
        raw_step();
        chk_eq("rst_pre_a", bus.mem_a, 32'h12);
        #2 rst = 0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 8; i++) begin
            raw_step();
            chk_eq("rst_no_fetch", {31'd0, bus.out_if_ready}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
